multi_way_tlc: RTL and testbench
================================

Name: multi_way_tlc

Overview:
- Parametrised successor to the two-road traffic light controller.
- Supports NUM_DIRS approaches with round-robin service of approaches whose sensor is asserted.
- Uses counter-timed GREEN_MIN/GREEN_MAX, YELLOW and all-red clearance phases, plus an emergency pre-emption input.
- Sits between the traffic sensor front end and the lamp drivers.

Parameters:
- NUM_DIRS, 4, number of approaches; legal range >= 2.
- GREEN_MIN, 8, minimum green length in cycles; legal range >= 1.
- GREEN_MAX, 32, green length at which a change is forced when another approach is waiting; must be >= GREEN_MIN.
- YELLOW_T, 3, yellow length in cycles; legal range >= 1.
- RED_T, 2, minimum all-red clearance length in cycles; legal range >= 1.
- DIR_W, $clog2(NUM_DIRS), width of the direction index (derived).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sensor  in  NUM_DIRS  per-approach traffic present, level-sensitive, synchronous to clk.
- emerg  in  1  emergency pre-emption request, level-sensitive.
- red  out  NUM_DIRS  red lamp per approach.
- yellow  out  NUM_DIRS  yellow lamp per approach.
- green  out  NUM_DIRS  green lamp per approach.
- active_dir  out  DIR_W  index of the approach currently or most recently served.
- phase  out  2  current phase: 00 ALL_RED, 01 GREEN, 10 YELLOW; 11 never produced.

Behaviour:
- Reset (rst=0), asynchronous:
  - phase=ALL_RED, active_dir=NUM_DIRS-1, phase counter=0.
  - red=all ones, yellow=0, green=0.
  - Takes effect immediately, including mid-phase; no output glitch beyond the async transition.
- Outputs are registered or decoded only from registered state.
  - Invariant: exactly one of red/yellow/green is set per approach.
  - At most one approach is non-red.
  - During GREEN: green[active_dir]=1. During YELLOW: yellow[active_dir]=1. All other lamps red.
- Phase counter k clears on every phase entry and increments each cycle.
  - In GREEN, k saturates at GREEN_MAX-1.
  - In ALL_RED, k saturates at RED_T-1.
- other_req is the OR of sensor over all approaches except active_dir.
- ALL_RED, evaluated in cycle k:
  - Exit to GREEN at the end of a cycle where k >= RED_T-1 and emerg=0.
  - The new active_dir is the first index with sensor=1, searching active_dir+1, active_dir+2, ... modulo NUM_DIRS, with active_dir itself checked last.
  - If no sensor is set, the new active_dir is (active_dir+1) mod NUM_DIRS (default rotation).
  - While emerg=1, stay in ALL_RED indefinitely.
- GREEN, evaluated in cycle k:
  - Go to YELLOW if emerg=1, at any k, overriding GREEN_MIN.
  - Otherwise go to YELLOW if k >= GREEN_MIN-1 and other_req=1 and either sensor[active_dir]=0 or k >= GREEN_MAX-1.
  - With other_req=0, green holds indefinitely, whatever the state of its own sensor.
- YELLOW: lasts exactly YELLOW_T cycles regardless of emerg, then ALL_RED.
- Nominal phase durations:
  - Green lasts GREEN_MIN..GREEN_MAX cycles when demand exists elsewhere.
  - Yellow lasts exactly YELLOW_T cycles.
  - All-red lasts RED_T cycles, plus any time emerg is held.
- Simultaneous events:
  - emerg has priority over all timing.
  - A sensor change in the same cycle as the decision is honoured, since sensor is sampled combinationally into the next-state logic.
- Direction wrap-around: the search index wraps NUM_DIRS-1 -> 0. For non-power-of-two NUM_DIRS, index values >= NUM_DIRS are never produced.
- Widths: the counter is sized to hold max(GREEN_MAX, YELLOW_T, RED_T)-1; no overflow is possible because of saturation.

Test Plan:
- Reset and idle:
  - Stimulus: rst=0, then release with sensor=0000.
  - Required: all red, active_dir=3, phase=00. After 2 cycles green[0]=1 and phase=01. Green[0] is held for 100+ cycles.
- Gap-out (green on 0):
  - Stimulus: sensor=0100 from green cycle 0.
  - Required: green[0] for exactly 8 cycles, yellow[0] for 3, all-red for 2, then green[2] and active_dir=2.
- Max-out rotation:
  - Stimulus: sensor=1111 constant.
  - Required: each green lasts exactly 32 cycles; service order 0,1,2,3,0; yellow 3 and all-red 2 between greens.
- Wrap search:
  - Stimulus: green on 3, sensor=0010 with sensor[3]=0.
  - Required: green[3] ends after 8 cycles, approach 0 is skipped, green[1] follows.
- Emergency:
  - Stimulus: emerg=1 at green cycle 2 of approach 1, held 10 cycles.
  - Required: yellow[1] on the next edge for 3 cycles; all-red held until emerg=0; green returns 1 cycle later, since k already >= RED_T-1.
- Reset mid-phase:
  - Stimulus: rst=0 during yellow cycle 1.
  - Required: outputs go all-red immediately (async) and active_dir=3. After release, the first green is on approach 0 after 2 all-red cycles.

Source files
------------

// File: rtl/multi_way_tlc_if.sv
// Sensor/lamp bundle between the sensor front end, the controller and the lamp drivers.
interface multi_way_tlc_if #(
    parameter int unsigned NUM_DIRS = 4,
    parameter int unsigned DIR_W    = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1
);
    logic [NUM_DIRS-1:0] sensor;
    logic                emerg;
    logic [NUM_DIRS-1:0] red;
    logic [NUM_DIRS-1:0] yellow;
    logic [NUM_DIRS-1:0] green;
    logic [DIR_W-1:0]    active_dir;
    logic [1:0]          phase;

    // Environment side: drives requests, observes lamps.
    modport master (
        output sensor,
        output emerg,
        input  red,
        input  yellow,
        input  green,
        input  active_dir,
        input  phase
    );

    // Controller side.
    modport slave (
        input  sensor,
        input  emerg,
        output red,
        output yellow,
        output green,
        output active_dir,
        output phase
    );
endinterface

// File: rtl/multi_way_tlc.sv
// Multi-approach traffic light controller: round-robin service of requesting
// approaches with timed green/yellow/all-red phases and emergency pre-emption.
module multi_way_tlc #(
    parameter int unsigned NUM_DIRS  = 4,
    parameter int unsigned GREEN_MIN = 8,
    parameter int unsigned GREEN_MAX = 32,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned RED_T     = 2
) (
    input  logic           clk,
    input  logic           rst,
    multi_way_tlc_if.slave bus
);
    localparam int unsigned DIR_W  = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
    localparam int unsigned MAX_GY = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int unsigned MAX_T  = (MAX_GY > RED_T) ? MAX_GY : RED_T;
    localparam int unsigned CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(RED_T - 1);
    localparam logic [DIR_W-1:0] DIR_LAST  = DIR_W'(NUM_DIRS - 1);

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [DIR_W-1:0]    dir_q, dir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_DIRS-1:0] red_q, red_d;
    logic [NUM_DIRS-1:0] yellow_q, yellow_d;
    logic [NUM_DIRS-1:0] green_q, green_d;

    logic [DIR_W-1:0]    next_dir_c;
    logic                search_hit_c;
    logic                other_req_c;
    logic                own_req_c;
    logic [NUM_DIRS-1:0] dir_sel_c;

    // Demand from every approach except the one holding the right of way.
    always_comb begin
        other_req_c = |(bus.sensor & ~(NUM_DIRS'(1) << dir_q));
        own_req_c   = bus.sensor[dir_q];
    end

    // Round-robin search starting after the current approach, current one last;
    // falls back to plain rotation when nobody is asking.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        search_hit_c = 1'b0;
        next_dir_c   = '0;
        for (int unsigned i = 1; i <= NUM_DIRS; i++) begin
            idx = 32'(dir_q) + i;
            if (idx >= NUM_DIRS) begin
                idx = idx - NUM_DIRS;
            end
            if (i == 1) begin
                next_dir_c = DIR_W'(idx);
            end
            if (!search_hit_c && (|(bus.sensor & (NUM_DIRS'(1) << idx)))) begin
                search_hit_c = 1'b1;
                next_dir_c   = DIR_W'(idx);
            end
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH_ALL_RED;
            dir_q   <= DIR_LAST;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: phase transitions, direction selection and phase counter.
    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        unique case (phase_q)
            PH_ALL_RED: begin
                if (cnt_q >= RED_LAST && !bus.emerg) begin
                    phase_d = PH_GREEN;
                    dir_d   = next_dir_c;
                    cnt_d   = '0;
                end else if (cnt_q < RED_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_GREEN: begin
                if (bus.emerg ||
                    (cnt_q >= GMIN_LAST && other_req_c &&
                     (!own_req_c || cnt_q >= GMAX_LAST))) begin
                    phase_d = PH_YELLOW;
                    cnt_d   = '0;
                end else if (cnt_q < GMAX_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PH_YELLOW: begin
                if (cnt_q >= YEL_LAST) begin
                    phase_d = PH_ALL_RED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                cnt_d   = '0;
            end
        endcase
    end

    // Lamp decode from the upcoming state so the lamp flops track the phase flops.
    always_comb begin
        red_d     = '1;
        yellow_d  = '0;
        green_d   = '0;
        dir_sel_c = NUM_DIRS'(1) << dir_d;
        case (phase_d)
            PH_GREEN: begin
                red_d   = ~dir_sel_c;
                green_d = dir_sel_c;
            end
            PH_YELLOW: begin
                red_d    = ~dir_sel_c;
                yellow_d = dir_sel_c;
            end
            default: begin
            end
        endcase
    end

    // Lamp output registers; reset lands on all-red.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
        end else begin
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
        end
    end

    assign bus.red        = red_q;
    assign bus.yellow     = yellow_q;
    assign bus.green      = green_q;
    assign bus.active_dir = dir_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_multi_way_tlc.sv
// Directed bench for multi_way_tlc with default timing (4 approaches, 8/32/3/2).
module tb_multi_way_tlc;
    localparam int unsigned ND = 4;
    localparam logic [1:0] PH_AR = 2'b00;
    localparam logic [1:0] PH_G  = 2'b01;
    localparam logic [1:0] PH_Y  = 2'b10;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multi_way_tlc_if #(.NUM_DIRS(ND)) bus ();

    multi_way_tlc #(
        .NUM_DIRS (ND),
        .GREEN_MIN(8),
        .GREEN_MAX(32),
        .YELLOW_T (3),
        .RED_T    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_v;
        logic [3:0] sensor;
        logic       emerg;
        int         cycles;
        logic [1:0] exp_phase;
        logic [1:0] exp_dir;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lamps();
        int bad;
        int nonred;
        bad    = 0;
        nonred = 0;
        for (int i = 0; i < ND; i++) begin
            if ((32'(bus.red[i]) + 32'(bus.yellow[i]) + 32'(bus.green[i])) != 1) bad++;
            if (bus.red[i] !== 1'b1) nonred++;
        end
        if (bus.phase === 2'b11) bad++;
        checks++;
        if (bad != 0 || nonred > 1) begin
            errors++;
            $display("FAIL lamp_invariant @%0t: got %0d bad / %0d non-red, expected 0 / <=1",
                     $time, bad, nonred);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_lamps();
    endtask

    task automatic check_state(input string name, input logic [1:0] ph, input logic [1:0] d);
        logic [3:0] sel;
        logic [3:0] er;
        logic [3:0] ey;
        logic [3:0] eg;
        sel = 4'b0001 << d;
        er  = 4'b1111;
        ey  = 4'b0000;
        eg  = 4'b0000;
        if (ph == PH_G) begin
            eg = sel;
            er = ~sel;
        end else if (ph == PH_Y) begin
            ey = sel;
            er = ~sel;
        end
        check_val($sformatf("%s phase", name), 32'(bus.phase), 32'(ph));
        check_val($sformatf("%s active_dir", name), 32'(bus.active_dir), 32'(d));
        check_val($sformatf("%s red", name), 32'(bus.red), 32'(er));
        check_val($sformatf("%s yellow", name), 32'(bus.yellow), 32'(ey));
        check_val($sformatf("%s green", name), 32'(bus.green), 32'(eg));
    endtask

    // Count cycles spent in (phase, dir) starting from the currently sampled cycle.
    task automatic measure(input string name, input logic [1:0] ph, input logic [1:0] d,
                           input int exp_len);
        int n;
        n = 0;
        while (bus.phase === ph && bus.active_dir === d && n < 200) begin
            n++;
            tick();
        end
        check_val(name, 32'(n), 32'(exp_len));
    endtask

    task automatic do_reset(input logic [3:0] s);
        rst        = 1'b0;
        bus.emerg  = 1'b0;
        bus.sensor = s;
        #1;
        check_state("reset_async", PH_AR, 2'd3);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.sensor = 4'b0000;
        bus.emerg  = 1'b0;
        #2;

        //            rst   sensor   emerg cyc  phase  dir
        vecs[0]  = '{1'b0, 4'b0000, 1'b0, 0,   PH_AR, 2'd3};
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 2,   PH_AR, 2'd3};
        vecs[2]  = '{1'b1, 4'b0000, 1'b0, 1,   PH_AR, 2'd3};
        vecs[3]  = '{1'b1, 4'b0000, 1'b0, 1,   PH_G,  2'd0};
        vecs[4]  = '{1'b1, 4'b0000, 1'b0, 120, PH_G,  2'd0};
        vecs[5]  = '{1'b1, 4'b0000, 1'b1, 1,   PH_Y,  2'd0};
        vecs[6]  = '{1'b1, 4'b0000, 1'b0, 2,   PH_Y,  2'd0};
        vecs[7]  = '{1'b1, 4'b0000, 1'b0, 1,   PH_AR, 2'd0};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 5,   PH_AR, 2'd0};
        vecs[9]  = '{1'b1, 4'b0000, 1'b0, 1,   PH_G,  2'd1};
        vecs[10] = '{1'b1, 4'b0100, 1'b0, 7,   PH_G,  2'd1};
        vecs[11] = '{1'b1, 4'b0100, 1'b0, 1,   PH_Y,  2'd1};
        vecs[12] = '{1'b1, 4'b0100, 1'b0, 3,   PH_AR, 2'd1};
        vecs[13] = '{1'b1, 4'b0100, 1'b0, 1,   PH_AR, 2'd1};
        vecs[14] = '{1'b1, 4'b0100, 1'b0, 1,   PH_G,  2'd2};
        vecs[15] = '{1'b1, 4'b0110, 1'b0, 31,  PH_G,  2'd2};
        vecs[16] = '{1'b1, 4'b0110, 1'b0, 1,   PH_Y,  2'd2};
        vecs[17] = '{1'b1, 4'b0110, 1'b0, 5,   PH_G,  2'd1};

        for (int i = 0; i < NV; i++) begin
            rst        = vecs[i].rst_v;
            bus.sensor = vecs[i].sensor;
            bus.emerg  = vecs[i].emerg;
            if (vecs[i].cycles == 0) #1;
            else repeat (vecs[i].cycles) tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_phase, vecs[i].exp_dir);
        end

        // Gap-out on approach 0 towards approach 2.
        do_reset(4'b0000);
        tick();
        tick();
        check_state("gap_start", PH_G, 2'd0);
        bus.sensor = 4'b0100;
        measure("gap_green0_len", PH_G, 2'd0, 8);
        measure("gap_yellow0_len", PH_Y, 2'd0, 3);
        measure("gap_allred_len", PH_AR, 2'd0, 2);
        check_state("gap_green2", PH_G, 2'd2);

        // Max-out rotation with every approach requesting.
        do_reset(4'b1111);
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            measure($sformatf("max_green%0d_len", d), PH_G, 2'(d), 32);
            measure($sformatf("max_yellow%0d_len", d), PH_Y, 2'(d), 3);
            measure($sformatf("max_allred%0d_len", d), PH_AR, 2'(d), 2);
        end
        check_state("max_back_to_0", PH_G, 2'd0);

        // Move to approach 3, then wrap past 0 to approach 1.
        bus.sensor = 4'b1000;
        measure("to3_green0_len", PH_G, 2'd0, 8);
        measure("to3_yellow0_len", PH_Y, 2'd0, 3);
        measure("to3_allred_len", PH_AR, 2'd0, 2);
        check_state("wrap_green3", PH_G, 2'd3);
        bus.sensor = 4'b0010;
        measure("wrap_green3_len", PH_G, 2'd3, 8);
        measure("wrap_yellow3_len", PH_Y, 2'd3, 3);
        measure("wrap_allred_len", PH_AR, 2'd3, 2);
        check_state("wrap_green1", PH_G, 2'd1);

        // Emergency at green cycle 2 of approach 1, held 10 cycles.
        tick();
        tick();
        check_state("emerg_pre", PH_G, 2'd1);
        bus.emerg = 1'b1;
        tick();
        check_state("emerg_yellow", PH_Y, 2'd1);
        measure("emerg_yellow_len", PH_Y, 2'd1, 3);
        for (int i = 0; i < 6; i++) begin
            check_state($sformatf("emerg_hold%0d", i), PH_AR, 2'd1);
            tick();
        end
        check_state("emerg_hold_last", PH_AR, 2'd1);
        bus.emerg = 1'b0;
        tick();
        check_state("emerg_release_green", PH_G, 2'd1);

        // Asynchronous reset in yellow cycle 1.
        bus.sensor = 4'b0001;
        measure("mid_green1_len", PH_G, 2'd1, 8);
        tick();
        check_state("mid_yellow1", PH_Y, 2'd1);
        rst = 1'b0;
        #1;
        check_state("mid_async_reset", PH_AR, 2'd3);
        tick();
        check_state("mid_in_reset", PH_AR, 2'd3);
        rst        = 1'b1;
        bus.sensor = 4'b0000;
        tick();
        check_state("mid_allred1", PH_AR, 2'd3);
        tick();
        check_state("mid_first_green", PH_G, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
